// File: rtl/onehot_step_fsm_pkg.sv
// Shared types and helpers for the one-hot stepping sequencer.
package fsm_pkg;

    localparam int MAX_STATES = 32;
    localparam int DWELL_MAX  = 255;
    localparam int DWELL_W    = 8;

    typedef enum logic [1:0] {
        CMD_HOLD    = 2'b00,
        CMD_ADV     = 2'b01,
        CMD_RET     = 2'b10,
        CMD_RESTART = 2'b11
    } cmd_e;

    function automatic logic [MAX_STATES-1:0] onehot_of(input logic [4:0] idx);
        return {{(MAX_STATES-1){1'b0}}, 1'b1} << idx;
    endfunction

    // A disabled cycle is indistinguishable from HOLD.
    function automatic cmd_e decode_cmd(input logic en, input logic a, input logic b);
        cmd_e cmd;
        cmd = CMD_HOLD;
        if (en) begin
            case ({b, a})
                2'b01:   cmd = CMD_ADV;
                2'b10:   cmd = CMD_RET;
                2'b11:   cmd = CMD_RESTART;
                default: cmd = CMD_HOLD;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/onehot_step_fsm_dwell_counter.sv
// Minimum-dwell timer: counts enabled cycles since the last state change, saturating at DWELL.
module dwell_counter
    import fsm_pkg::*;
#(
    parameter int DWELL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic ready
);

    generate
        if (DWELL == 0) begin : g_no_dwell
            logic unused_in;
            assign unused_in = ^{clk, rst, en, clear};
            assign ready     = 1'b1;
        end else begin : g_dwell
            localparam logic [DWELL_W-1:0] LIMIT = DWELL_W'(DWELL);

            logic [DWELL_W-1:0] cnt_q;
            logic [DWELL_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (en && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign ready = (cnt_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/onehot_step_fsm.sv
// One-hot stepping sequencer: the binary index is the single source of truth,
// the one-hot vector and status flags are registered copies derived from its next value.
//
//   command      | meaning
//   CMD_HOLD     | no request or en=0; state and flags idle
//   CMD_ADV      | step to index+1 once dwell has elapsed
//   CMD_RET      | step to index-1 once dwell has elapsed
//   CMD_RESTART  | jump to index 0 at once, restart the dwell interval
module onehot_step_fsm
    import fsm_pkg::*;
#(
    parameter int N_STATES = 4,
    parameter int WRAP     = 0,
    parameter int DWELL    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        a,
    input  logic                        b,
    output logic [N_STATES-1:0]         state,
    output logic [$clog2(N_STATES)-1:0] state_idx,
    output logic                        at_first,
    output logic                        at_last,
    output logic                        moved,
    output logic                        blocked
);

    localparam int              IDX_W = $clog2(N_STATES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_STATES - 1);

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_STATES-1:0] state_q, state_d;
    logic                at_first_q, at_first_d;
    logic                at_last_q, at_last_d;
    logic                moved_q, moved_d;
    logic                blocked_q, blocked_d;
    logic                dwell_clear;
    logic                ready;
    cmd_e                cmd;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (dwell_clear),
        .ready (ready)
    );

    always_comb begin
        cmd         = decode_cmd(en, a, b);
        idx_d       = idx_q;
        blocked_d   = 1'b0;
        dwell_clear = 1'b0;

        case (cmd)
            CMD_ADV: begin
                if (ready) begin
                    if (idx_q != LAST) begin
                        idx_d = idx_q + 1'b1;
                    end else if (WRAP != 0) begin
                        idx_d = '0;
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
            end
            CMD_RET: begin
                if (ready) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else if (WRAP != 0) begin
                        idx_d = LAST;
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
            end
            CMD_RESTART: begin
                idx_d       = '0;
                dwell_clear = 1'b1;
            end
            default: begin
            end
        endcase

        // Any real change of index restarts the dwell interval.
        moved_d = (idx_d != idx_q);
        if (moved_d) begin
            dwell_clear = 1'b1;
        end

        state_d    = N_STATES'(onehot_of(5'(idx_d)));
        at_first_d = (idx_d == '0);
        at_last_d  = (idx_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            state_q    <= N_STATES'(1);
            at_first_q <= 1'b1;
            at_last_q  <= 1'b0;
            moved_q    <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            state_q    <= state_d;
            at_first_q <= at_first_d;
            at_last_q  <= at_last_d;
            moved_q    <= moved_d;
            blocked_q  <= blocked_d;
        end
    end

    assign state     = state_q;
    assign state_idx = idx_q;
    assign at_first  = at_first_q;
    assign at_last   = at_last_q;
    assign moved     = moved_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_onehot_step_fsm.sv
// Bench for onehot_step_fsm: four configurations share one stimulus stream and are
// compared every cycle against an index-level reference model, plus directed literal checks.
module tb_onehot_step_fsm;

    localparam int NI = 4;
    localparam int CN[NI] = '{4, 4, 4, 7};
    localparam int CW[NI] = '{0, 1, 0, 1};
    localparam int CD[NI] = '{0, 0, 2, 0};

    logic clk = 1'b0;
    logic rst, en, a, b;

    logic [3:0] s0, s1, s2;
    logic [6:0] s3;
    logic [1:0] i0, i1, i2;
    logic [2:0] i3;
    logic f0, f1, f2, f3, l0, l1, l2, l3;
    logic m0, m1, m2, m3, k0, k1, k2, k3;

    int  m_idx[NI];
    int  m_cnt[NI];
    bit  m_mv[NI];
    bit  m_bl[NI];
    bit  cmp_en = 1'b0;
    int  n_pass = 0;
    int  n_total = 0;

    always #5 clk = ~clk;

    onehot_step_fsm #(.N_STATES(4), .WRAP(0), .DWELL(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .state(s0), .state_idx(i0),
        .at_first(f0), .at_last(l0), .moved(m0), .blocked(k0));
    onehot_step_fsm #(.N_STATES(4), .WRAP(1), .DWELL(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .state(s1), .state_idx(i1),
        .at_first(f1), .at_last(l1), .moved(m1), .blocked(k1));
    onehot_step_fsm #(.N_STATES(4), .WRAP(0), .DWELL(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .state(s2), .state_idx(i2),
        .at_first(f2), .at_last(l2), .moved(m2), .blocked(k2));
    onehot_step_fsm #(.N_STATES(7), .WRAP(1), .DWELL(0)) u3 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .state(s3), .state_idx(i3),
        .at_first(f3), .at_last(l3), .moved(m3), .blocked(k3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [40:0] pk(input logic [31:0] s, input logic [4:0] i,
                                       input logic af, input logic al,
                                       input logic mv, input logic bl);
        return {s, i, af, al, mv, bl};
    endfunction

    function automatic logic [40:0] model_pk(input int k);
        logic [31:0] s;
        s = 32'h1 << m_idx[k];
        return pk(s, 5'(m_idx[k]), m_idx[k] == 0, m_idx[k] == CN[k] - 1, m_mv[k], m_bl[k]);
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_mv[k] = 0; m_bl[k] = 0;
        end
    end

    // Reference model: index arithmetic straight from the stepping rules.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_idx[k] = 0; m_cnt[k] = 0; m_mv[k] = 0; m_bl[k] = 0;
            end else begin
                int tgt;
                bit restart;
                m_mv[k] = 0;
                m_bl[k] = 0;
                restart = 0;
                if (en === 1'b1) begin
                    if (a && b) begin
                        restart  = 1;
                        m_mv[k]  = (m_idx[k] != 0);
                        m_idx[k] = 0;
                    end else if ((a != b) && (m_cnt[k] == CD[k])) begin
                        tgt = m_idx[k] + (a ? 1 : -1);
                        if (tgt < 0 || tgt >= CN[k]) begin
                            if (CW[k] != 0) begin
                                tgt = (tgt + CN[k]) % CN[k];
                            end else begin
                                m_bl[k] = 1;
                                tgt = m_idx[k];
                            end
                        end
                        if (tgt != m_idx[k]) begin
                            m_idx[k] = tgt;
                            m_mv[k]  = 1;
                        end
                    end
                    if (restart || m_mv[k]) m_cnt[k] = 0;
                    else if (m_cnt[k] < CD[k]) m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_u0", 64'(pk(32'(s0), 5'(i0), f0, l0, m0, k0)), 64'(model_pk(0)));
            chk("cyc_u1", 64'(pk(32'(s1), 5'(i1), f1, l1, m1, k1)), 64'(model_pk(1)));
            chk("cyc_u2", 64'(pk(32'(s2), 5'(i2), f2, l2, m2, k2)), 64'(model_pk(2)));
            chk("cyc_u3", 64'(pk(32'(s3), 5'(i3), f3, l3, m3, k3)), 64'(model_pk(3)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0;
        #20;
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_state", 64'(s0), 64'(4'b0001));
        chk("rst_first", 64'(f0), 64'd1);
        chk("rst_moved", 64'(m0), 64'd0);

        en = 1'b1; a = 1'b1; b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("walk_state%0d", i), 64'(s0), 64'(4'b0010 << i));
            chk($sformatf("walk_moved%0d", i), 64'(m0), 64'd1);
        end
        tick();
        chk("end_state", 64'(s0), 64'(4'b1000));
        chk("end_blocked", 64'(k0), 64'd1);
        chk("end_last", 64'(l0), 64'd1);
        chk("wrap_adv", 64'(s1), 64'(4'b0001));

        a = 1'b0; b = 1'b1;
        tick();
        chk("wrap_ret", 64'(s1), 64'(4'b1000));
        chk("ret_state", 64'(s0), 64'(4'b0100));

        a = 1'b1; b = 1'b1;
        tick();
        chk("restart_state", 64'(s0), 64'(4'b0001));
        chk("restart_moved", 64'(m0), 64'd1);
        tick();
        chk("restart2_state", 64'(s0), 64'(4'b0001));
        chk("restart2_moved", 64'(m0), 64'd0);

        a = 1'b0; b = 1'b1;
        tick();
        chk("first_blocked", 64'(k0), 64'd1);
        chk("first_state", 64'(s0), 64'(4'b0001));

        do_reset();
        en = 1'b1; a = 1'b1; b = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("dwell_state%0d", e), 64'(s2), 64'(4'b0001 << (e / 3)));
            chk($sformatf("dwell_moved%0d", e), 64'(m2), 64'((e % 3) == 0));
        end

        do_reset();
        en = 1'b1; a = 1'b1;
        tick();
        en = 1'b0;
        tick();
        tick();
        chk("en_hold3", 64'(s2), 64'(4'b0001));
        en = 1'b1;
        tick();
        chk("en_hold4", 64'(s2), 64'(4'b0001));
        tick();
        chk("en_step5", 64'(s2), 64'(4'b0010));
        chk("en_moved5", 64'(m2), 64'd1);

        do_reset();
        en = 1'b1; a = 1'b1; b = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("n7_idx%0d", e), 64'(i3), 64'(e % 7));
        end
        chk("n7_state", 64'(s3), 64'(7'b0000001));

        do_reset();
        en = 1'b1; a = 1'b1; b = 1'b0;
        tick();
        tick();
        chk("mid_before", 64'(s0), 64'(4'b0100));
        rst = 1'b1;
        #1;
        chk("mid_state", 64'(s0), 64'(4'b0001));
        chk("mid_idx", 64'(i0), 64'd0);
        chk("mid_first", 64'(f0), 64'd1);
        a = 1'b0;
        tick();
        rst = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            int r;
            r  = $urandom_range(7);
            en = ($urandom_range(3) != 0);
            a  = (r <= 2) || (r == 6);
            b  = ((r >= 3) && (r <= 5)) || (r == 6);
            rst = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/onehot_step_fsm.md
# onehot_step_fsm

Parametrised one-hot stepping state machine, the next generation of the fixed 4-state `a`/`b` controller. It walks a one-hot state vector of configurable length forward or backward on two request inputs. Optional end-of-range wrap, a minimum-dwell interval per state and a synchronous restart command are configurable. It is used as the sequencing core of FSM benchmark designs and exposes registered status flags for the surrounding control logic and testbench checks.

## Interface
- `N_STATES`, 4: number of states; legal range 2..32; the state vector is N_STATES bits wide.
- `WRAP`, 0: 1 = advance from last goes to first and retreat from first goes to last; 0 = saturate at the ends.
- `DWELL`, 0: minimum extra cycles a state must be held before any step; legal range 0..255.
- `clk` input 1: single clock; all state updates occur on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: step enable; 0 freezes state and dwell counter.
- `a` input 1: advance request.
- `b` input 1: retreat request.
- `state` output N_STATES: one-hot current state; bit 0 = first state.
- `state_idx` output $clog2(N_STATES): binary index of the current state.
- `at_first` output 1: current state is index 0.
- `at_last` output 1: current state is index N_STATES-1.
- `moved` output 1: one-cycle pulse; the state changed on the previous edge.
- `blocked` output 1: one-cycle pulse; the previous edge rejected a step at an end of range because WRAP=0.

## Operation
- Command decode (only when `en`=1): `a`&!`b` = ADVANCE, !`a`&`b` = RETREAT, `a`&`b` = RESTART, neither = HOLD.
- Dwell counter:
  - Clears to 0 whenever the state changes.
  - Increments once per enabled cycle and saturates at DWELL.
  - ADVANCE and RETREAT are permitted only when the counter equals DWELL.
  - When a step is not permitted, it is silently ignored: no `blocked` pulse, and the request is not queued.
- ADVANCE: the state index goes to index+1. At the last state: WRAP=1 goes to index 0; WRAP=0 holds and pulses `blocked`.
- RETREAT: the state index goes to index-1. At index 0: WRAP=1 goes to N_STATES-1; WRAP=0 holds and pulses `blocked`.
- RESTART: forces index 0 regardless of dwell. It pulses `moved` only if the index was not already 0. It also clears the dwell counter.
- HOLD or `en`=0: no change; `moved` and `blocked` are 0 on the next cycle.
- `state` is always exactly one-hot. `state_idx`, `at_first` and `at_last` are always consistent with `state`.
- Index arithmetic is unsigned modulo N_STATES with WRAP=1. No intermediate value leaves the range 0..N_STATES-1.

## Timing
- Reset values: `state`=1 (index 0), `state_idx`=0, `at_first`=1, `at_last`=0, `moved`=0, `blocked`=0, dwell counter=0.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge. Any in-progress dwell interval is discarded.
- Latency:
  - Inputs are sampled on the rising edge; all outputs are registered and reflect that edge.
  - `moved` and `blocked` are high for exactly the one cycle following the deciding edge.
- With a request held continuously, each state is held DWELL+1 cycles. DWELL=0 gives one step per cycle.
- `en` deasserted for k cycles extends the dwell interval by k cycles.

## Structure
- Shared package `fsm_pkg`:
  - 2-bit command encoding CMD_HOLD/CMD_ADV/CMD_RET/CMD_RESTART.
  - Function onehot_of(idx).
- Sub-module `dwell_counter`:
  - Parameter DWELL.
  - Inputs `clk`, `rst`, `en`, `clear`; output `ready` (count == DWELL).
  - With DWELL=0, `ready` is tied to 1 and no counter flops are generated.
- Top level:
  - Holds the binary index register as the single source of truth.
  - `state` is derived registered from the index.
  - Contains the command decoder.

## Test plan
- Reset defaults (N=4, WRAP=0, DWELL=0): `rst` high 20 ns, then low -> `state`=0001, `at_first`=1, `moved`=0. Assert `rst` mid-walk at 0100 -> `state`=0001 before the next edge.
- Forward walk: `a`=1, `b`=0 for 3 cycles -> `state` 0010, 0100, 1000 with `moved`=1 each cycle. A 4th cycle -> stays 1000 with `blocked`=1 and `at_last`=1.
- Wrap: with WRAP=1, from 1000 apply `a` for 1 cycle -> 0001. From 0001 apply `b` -> 1000.
- Restart and simultaneous inputs: from 0100 apply `a`=`b`=1 -> 0001 with `moved`=1. Apply it again -> 0001 with `moved`=0.
- Dwell and enable: with DWELL=2, `a` held from reset -> changes at edges 3, 6 and 9. Dropping `en` for 2 cycles mid-interval -> the next change is delayed by 2 cycles.
- Width: with N_STATES=7 and WRAP=1, advance 7 times -> returns to 0000001, with `state_idx` stepping through 0..6, 0.
